controle_multiciclo: RTL and testbench

Multicycle control unit for the 64-bit RISC-V datapath (`UP`). A Moore FSM with a memory-wait counter decodes the instruction register fields and drives every datapath load enable, mux select and ALU operation, one instruction at a time. It replaces hand-driven control signals in `simulacao32`. It also exposes state and halt/error status for the bench.

---
 rtl/controle_multiciclo.sv | 224 ++++++++++++++++++++++
 tb/tb_controle_multiciclo.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/controle_multiciclo.sv
// Multicycle control unit for the 64-bit RISC-V datapath.
// Moore FSM with a memory-wait counter. Outputs are registered from the next state.
module controle_multiciclo #(
  parameter int MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] i6_0,
  input  logic [2:0] i14_12,
  input  logic [6:0] i31_25,
  input  logic       AluIgual,
  output logic       PCwrite,
  output logic       MemRead,
  output logic       LoadIR,
  output logic       RegWrite,
  output logic       loadRegA,
  output logic       loadRegB,
  output logic       loadRegAluOut,
  output logic       loadRegMemData,
  output logic       SelMux2,
  output logic [1:0] SelMux4,
  output logic [2:0] SelMuxMem,
  output logic       SelMuxPC,
  output logic [2:0] AluOperation,
  output logic [3:0] estado,
  output logic       halt,
  output logic       erro
);

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM_RD = 4'd6,
    S_MEM_WR = 4'd7,
    S_WB_ALU = 4'd8,
    S_WB_MEM = 4'd9,
    S_BRANCH = 4'd10,
    S_WB_LUI = 4'd11,
    S_HALT   = 4'd12,
    S_ERRO   = 4'd13
  } state_t;

  localparam logic [2:0] CNT_LAST = 3'(MEM_WAIT - 1);

  state_t     r_state;
  state_t     w_state_next;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_next;
  logic       r_is_ld;
  logic       r_br_en;
  logic       r_br_ne;

  logic       r_pcwrite, r_memread, r_loadir, r_regwrite;
  logic       r_lra, r_lrb, r_lao, r_lmd, r_selmux2, r_selmuxpc;
  logic [1:0] r_selmux4;
  logic [2:0] r_selmuxmem, r_aluop;
  logic       r_halt, r_erro;

  logic       w_pcwrite, w_memread, w_loadir, w_regwrite;
  logic       w_lra, w_lrb, w_lao, w_lmd, w_selmux2, w_selmuxpc;
  logic [1:0] w_selmux4;
  logic [2:0] w_selmuxmem, w_aluop;
  logic       w_halt, w_erro, w_br_en;

  logic       w_r_valid;
  logic [2:0] w_r_aluop;

  always_comb begin
    w_r_valid = 1'b0;
    w_r_aluop = 3'b000;
    if (i14_12 == 3'b000 && i31_25 == 7'b0000000) begin
      w_r_valid = 1'b1;
      w_r_aluop = 3'b001;
    end else if (i14_12 == 3'b000 && i31_25 == 7'b0100000) begin
      w_r_valid = 1'b1;
      w_r_aluop = 3'b010;
    end else if (i14_12 == 3'b111 && i31_25 == 7'b0000000) begin
      w_r_valid = 1'b1;
      w_r_aluop = 3'b011;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RESET:  w_state_next = S_FETCH;
      S_FETCH:  if (r_cnt == CNT_LAST) w_state_next = S_DECODE;
      S_DECODE: begin
        case (i6_0)
          7'b0110011: w_state_next = S_EXEC_R;
          7'b0010011: w_state_next = (i14_12 == 3'b000) ? S_EXEC_I : S_ERRO;
          7'b0000011: w_state_next = (i14_12 == 3'b011) ? S_ADDR : S_ERRO;
          7'b0100011: w_state_next = (i14_12 == 3'b111) ? S_ADDR : S_ERRO;
          7'b1100011: w_state_next = (i14_12[2:1] == 2'b00) ? S_BRANCH : S_ERRO;
          7'b0110111: w_state_next = S_WB_LUI;
          7'b1110011: w_state_next = S_HALT;
          default:    w_state_next = S_ERRO;
        endcase
      end
      S_EXEC_R: w_state_next = w_r_valid ? S_WB_ALU : S_ERRO;
      S_EXEC_I: w_state_next = S_WB_ALU;
      S_ADDR:   w_state_next = r_is_ld ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (r_cnt == CNT_LAST) w_state_next = S_WB_MEM;
      S_MEM_WR, S_WB_ALU, S_WB_MEM, S_WB_LUI, S_BRANCH: w_state_next = S_FETCH;
      S_HALT:   w_state_next = S_HALT;
      S_ERRO:   w_state_next = S_ERRO;
      default:  w_state_next = S_ERRO;
    endcase
  end

  // Only the memory-wait states ever dwell; everything else keeps cnt at zero.
  always_comb begin
    w_cnt_next = 3'd0;
    if (w_state_next == r_state && (r_state == S_FETCH || r_state == S_MEM_RD))
      w_cnt_next = r_cnt + 3'd1;
  end

  always_comb begin
    w_pcwrite = 1'b0; w_memread = 1'b0; w_loadir = 1'b0; w_regwrite = 1'b0;
    w_lra = 1'b0; w_lrb = 1'b0; w_lao = 1'b0; w_lmd = 1'b0;
    w_selmux2 = 1'b0; w_selmuxpc = 1'b0; w_selmux4 = 2'b00;
    w_selmuxmem = 3'b000; w_aluop = 3'b000;
    w_halt = 1'b0; w_erro = 1'b0; w_br_en = 1'b0;
    case (w_state_next)
      S_FETCH: begin
        if (w_cnt_next == CNT_LAST) begin
          w_loadir  = 1'b1;
          w_pcwrite = 1'b1;
          w_selmux4 = 2'b01;
          w_aluop   = 3'b001;
        end
      end
      S_DECODE: begin
        w_lra = 1'b1; w_lrb = 1'b1; w_lao = 1'b1;
        w_selmux4 = 2'b11;
        w_aluop   = 3'b001;
      end
      S_EXEC_R: begin
        w_selmux2 = 1'b1;
        w_lao     = 1'b1;
        w_aluop   = w_r_aluop;
      end
      S_EXEC_I, S_ADDR: begin
        w_selmux2 = 1'b1;
        w_selmux4 = 2'b10;
        w_aluop   = 3'b001;
        w_lao     = 1'b1;
      end
      S_MEM_RD: w_lmd = (w_cnt_next == CNT_LAST);
      S_MEM_WR: w_memread = 1'b1;
      S_WB_ALU: w_regwrite = 1'b1;
      S_WB_MEM: begin
        w_regwrite  = 1'b1;
        w_selmuxmem = 3'b001;
      end
      S_WB_LUI: begin
        w_regwrite  = 1'b1;
        w_selmuxmem = 3'b010;
      end
      S_BRANCH: begin
        w_selmux2  = 1'b1;
        w_aluop    = 3'b111;
        w_selmuxpc = 1'b1;
        w_br_en    = 1'b1;
      end
      S_HALT:  w_halt = 1'b1;
      S_ERRO:  w_erro = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_RESET;
      r_cnt   <= 3'd0;
      r_is_ld <= 1'b0;
      r_br_en <= 1'b0;
      r_br_ne <= 1'b0;
      r_pcwrite <= 1'b0; r_memread <= 1'b0; r_loadir <= 1'b0; r_regwrite <= 1'b0;
      r_lra <= 1'b0; r_lrb <= 1'b0; r_lao <= 1'b0; r_lmd <= 1'b0;
      r_selmux2 <= 1'b0; r_selmuxpc <= 1'b0; r_selmux4 <= 2'b00;
      r_selmuxmem <= 3'b000; r_aluop <= 3'b000;
      r_halt <= 1'b0; r_erro <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      // Latch the instruction kind while the IR fields are still being decoded.
      if (r_state == S_DECODE) begin
        r_is_ld <= (i6_0 == 7'b0000011);
        r_br_ne <= i14_12[0];
      end
      r_br_en <= w_br_en;
      r_pcwrite <= w_pcwrite; r_memread <= w_memread; r_loadir <= w_loadir;
      r_regwrite <= w_regwrite;
      r_lra <= w_lra; r_lrb <= w_lrb; r_lao <= w_lao; r_lmd <= w_lmd;
      r_selmux2 <= w_selmux2; r_selmuxpc <= w_selmuxpc; r_selmux4 <= w_selmux4;
      r_selmuxmem <= w_selmuxmem; r_aluop <= w_aluop;
      r_halt <= w_halt; r_erro <= w_erro;
    end
  end

  // The equality flag is only valid once RegA/RegB are loaded, so it gates PCwrite live.
  assign PCwrite        = r_pcwrite | (r_br_en & (AluIgual ^ r_br_ne));
  assign MemRead        = r_memread;
  assign LoadIR         = r_loadir;
  assign RegWrite       = r_regwrite;
  assign loadRegA       = r_lra;
  assign loadRegB       = r_lrb;
  assign loadRegAluOut  = r_lao;
  assign loadRegMemData = r_lmd;
  assign SelMux2        = r_selmux2;
  assign SelMux4        = r_selmux4;
  assign SelMuxMem      = r_selmuxmem;
  assign SelMuxPC       = r_selmuxpc;
  assign AluOperation   = r_aluop;
  assign estado         = r_state;
  assign halt           = r_halt;
  assign erro           = r_erro;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Scoreboard bench for controle_multiciclo: expected per-cycle state and
// control vectors are queued per instruction and compared each cycle.
module tb_controle_multiciclo;
  localparam int MW = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] i6_0 = 7'd0;
  logic [2:0] i14_12 = 3'd0;
  logic [6:0] i31_25 = 7'd0;
  logic       AluIgual = 1'b0;
  logic       PCwrite, MemRead, LoadIR, RegWrite;
  logic       loadRegA, loadRegB, loadRegAluOut, loadRegMemData;
  logic       SelMux2, SelMuxPC;
  logic [1:0] SelMux4;
  logic [2:0] SelMuxMem, AluOperation;
  logic [3:0] estado;
  logic       halt, erro;

  always #5 clk = ~clk;

  controle_multiciclo #(.MEM_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .i6_0(i6_0), .i14_12(i14_12), .i31_25(i31_25),
    .AluIgual(AluIgual), .PCwrite(PCwrite), .MemRead(MemRead), .LoadIR(LoadIR),
    .RegWrite(RegWrite), .loadRegA(loadRegA), .loadRegB(loadRegB),
    .loadRegAluOut(loadRegAluOut), .loadRegMemData(loadRegMemData),
    .SelMux2(SelMux2), .SelMux4(SelMux4), .SelMuxMem(SelMuxMem),
    .SelMuxPC(SelMuxPC), .AluOperation(AluOperation), .estado(estado),
    .halt(halt), .erro(erro)
  );

  logic [19:0] w_ctrl;
  assign w_ctrl = {PCwrite, MemRead, LoadIR, RegWrite, loadRegA, loadRegB,
                   loadRegAluOut, loadRegMemData, SelMux2, SelMux4, SelMuxMem,
                   SelMuxPC, AluOperation, halt, erro};

  typedef struct packed {
    logic [3:0]  st;
    logic [19:0] ctrl;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [19:0] cv(input logic pcw, input logic memw, input logic lir,
      input logic rw, input logic lra, input logic lrb, input logic lao, input logic lmd,
      input logic sm2, input logic [1:0] sm4, input logic [2:0] smm, input logic spc,
      input logic [2:0] aop, input logic hl, input logic er);
    return {pcw, memw, lir, rw, lra, lrb, lao, lmd, sm2, sm4, smm, spc, aop, hl, er};
  endfunction

  function automatic logic [19:0] c_fetch_last();
    return cv(1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 3'b000, 0, 3'b001, 0, 0);
  endfunction
  function automatic logic [19:0] c_decode();
    return cv(0, 0, 0, 0, 1, 1, 1, 0, 0, 2'b11, 3'b000, 0, 3'b001, 0, 0);
  endfunction
  function automatic logic [19:0] c_exec_r(input logic [2:0] aop);
    return cv(0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 3'b000, 0, aop, 0, 0);
  endfunction
  function automatic logic [19:0] c_exec_i();
    return cv(0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b10, 3'b000, 0, 3'b001, 0, 0);
  endfunction
  function automatic logic [19:0] c_mem_rd(input logic last);
    return cv(0, 0, 0, 0, 0, 0, 0, last, 0, 2'b00, 3'b000, 0, 3'b000, 0, 0);
  endfunction
  function automatic logic [19:0] c_mem_wr();
    return cv(0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 3'b000, 0, 0);
  endfunction
  function automatic logic [19:0] c_wb(input logic [2:0] smm);
    return cv(0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, smm, 0, 3'b000, 0, 0);
  endfunction
  function automatic logic [19:0] c_branch(input logic pcw);
    return cv(pcw, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b000, 1, 3'b111, 0, 0);
  endfunction
  function automatic logic [19:0] c_halt();
    return cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 3'b000, 1, 0);
  endfunction
  function automatic logic [19:0] c_erro();
    return cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 3'b000, 0, 1);
  endfunction

  task automatic push(input logic [3:0] st, input logic [19:0] ctrl);
    exp_t e;
    e.st = st;
    e.ctrl = ctrl;
    sb_q.push_back(e);
  endtask

  task automatic push_fetch_decode();
    for (int i = 0; i < MW - 1; i++) push(4'd1, 20'd0);
    push(4'd1, c_fetch_last());
    push(4'd2, c_decode());
  endtask

  // One clock per queued entry, so every drain is bounded by the queue length.
  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      @(posedge clk);
      #1;
      cyc++;
      e = sb_q.pop_front();
      check("estado", 32'(estado), 32'(e.st));
      check("ctrl", 32'(w_ctrl), 32'(e.ctrl));
    end
  endtask

  task automatic set_ir(input logic [31:0] ir);
    i6_0   = ir[6:0];
    i14_12 = ir[14:12];
    i31_25 = ir[31:25];
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    for (int i = 0; i < cycles; i++) push(4'd0, 20'd0);
    drain();
    rst = 1'b1;
  endtask

  task automatic run_rtype(input logic [31:0] ir, input logic [2:0] aop);
    set_ir(ir);
    push_fetch_decode();
    push(4'd3, c_exec_r(aop));
    push(4'd8, c_wb(3'b000));
    drain();
    $display("R-type ir=%08h aluop=%03b checked", ir, aop);
  endtask

  task automatic run_branch(input logic [2:0] f3, input logic eq, input logic pcw);
    set_ir({17'd0, f3, 5'd0, 7'b1100011});
    AluIgual = eq;
    push_fetch_decode();
    push(4'd10, c_branch(pcw));
    drain();
    $display("branch funct3=%03b AluIgual=%0b expected PCwrite=%0b", f3, eq, pcw);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(2);
    $display("reset checked");

    run_rtype(32'h002081B3, 3'b001);
    run_rtype(32'h402081B3, 3'b010);
    run_rtype(32'h0020F1B3, 3'b011);

    set_ir(32'h00108193);
    push_fetch_decode();
    push(4'd4, c_exec_i());
    push(4'd8, c_wb(3'b000));
    drain();
    $display("addi checked");

    set_ir({17'd0, 3'b011, 5'd0, 7'b0000011});
    push_fetch_decode();
    push(4'd5, c_exec_i());
    for (int i = 0; i < MW - 1; i++) push(4'd6, c_mem_rd(1'b0));
    push(4'd6, c_mem_rd(1'b1));
    push(4'd9, c_wb(3'b001));
    drain();
    $display("ld checked");

    set_ir({17'd0, 3'b111, 5'd0, 7'b0100011});
    push_fetch_decode();
    push(4'd5, c_exec_i());
    push(4'd7, c_mem_wr());
    drain();
    $display("sd checked");

    run_branch(3'b000, 1'b1, 1'b1);
    run_branch(3'b000, 1'b0, 1'b0);
    run_branch(3'b001, 1'b1, 1'b0);
    run_branch(3'b001, 1'b0, 1'b1);
    AluIgual = 1'b0;

    set_ir({25'd0, 7'b0110111});
    push_fetch_decode();
    push(4'd11, c_wb(3'b010));
    drain();
    $display("lui checked");

    // Reset pulled during the first MEM_RD cycle of a load.
    set_ir({17'd0, 3'b011, 5'd0, 7'b0000011});
    push_fetch_decode();
    push(4'd5, c_exec_i());
    push(4'd6, c_mem_rd(MW == 1));
    drain();
    do_reset(1);
    $display("mid-load reset checked");
    run_rtype(32'h002081B3, 3'b001);

    set_ir(32'h022081B3);
    push_fetch_decode();
    push(4'd3, c_exec_r(3'b000));
    for (int i = 0; i < 4; i++) push(4'd13, c_erro());
    drain();
    $display("illegal funct7 checked");
    do_reset(1);

    set_ir(32'h00100073);
    push_fetch_decode();
    for (int i = 0; i < 4; i++) push(4'd12, c_halt());
    drain();
    $display("ebreak checked");
    do_reset(1);

    set_ir(32'h00000000);
    push_fetch_decode();
    for (int i = 0; i < 2; i++) push(4'd13, c_erro());
    drain();
    $display("illegal opcode checked");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
